// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: FIFO of core commit records serialized as six 32-bit trace words over valid/ready.
module commit_trace_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_inst,
  input  logic        commit_halt,
  input  logic        commit_reg_we,
  input  logic [4:0]  commit_reg_wa,
  input  logic [31:0] commit_reg_wd,
  input  logic        commit_dmem_we,
  input  logic [31:0] commit_dmem_wa,
  input  logic [31:0] commit_dmem_wd,
  output logic        tr_valid,
  input  logic        tr_ready,
  output logic [31:0] tr_data,
  output logic        tr_last,
  output logic        stall_req,
  output logic        overflow,
  output logic        halted
);
  typedef enum logic {IDLE, SEND} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic        reg_we;
    logic        dmem_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic [31:0] dmem_wa;
    logic [31:0] dmem_wd;
  } rec_t;
  localparam logic [ADDR_W:0] FULL   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ALMOST = FULL - 1'b1;
  rec_t              mem_q [DEPTH];
  rec_t              head;
  rec_t              rec_in;
  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              stall_q, ovf_q, halted_q;
  logic              push, pop, hs;
  logic [31:0]       words [8];
  assign rec_in = '{commit_pc, commit_inst, commit_halt, commit_reg_we, commit_dmem_we,
                    commit_reg_wa, commit_reg_wd, commit_dmem_wa, commit_dmem_wd};
  always_comb begin
    head     = mem_q[rd_ptr_q];
    tr_valid = state_q == SEND;
    hs       = tr_valid && tr_ready;
    push     = commit && (count_q != FULL);
    pop      = hs && (idx_q == 3'd5);
    count_d  = count_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    idx_d    = hs ? (pop ? 3'd0 : idx_q + 3'd1) : idx_q;
    state_d  = (state_q == IDLE) ? ((count_q != '0) ? SEND : IDLE)
                                 : ((pop && count_d == '0) ? IDLE : SEND);
    words[0] = head.pc;
    words[1] = head.inst;
    words[2] = {head.halt, head.reg_we, head.dmem_we, 20'b0, head.reg_wa, 4'b0};
    words[3] = head.reg_wd;
    words[4] = head.dmem_wa;
    words[5] = head.dmem_wd;
    words[6] = '0;
    words[7] = '0;
    tr_data  = tr_valid ? words[idx_q] : '0;
    tr_last  = tr_valid && (idx_q == 3'd5);
  end
  // Storage needs no reset: the head is only observed while SEND, which implies a prior push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_in;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_q + {{(ADDR_W-1){1'b0}}, push};
      rd_ptr_q <= rd_ptr_q + {{(ADDR_W-1){1'b0}}, pop};
      count_q  <= count_d;
      stall_q  <= count_d >= ALMOST;
      ovf_q    <= ovf_q | (commit & ~push);
      halted_q <= halted_q | (pop & head.halt);
    end
  end
  assign stall_req = stall_q;
  assign overflow  = ovf_q;
  assign halted    = halted_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed vector tables plus randomized traffic against a queue-based record model.
module tb_commit_trace_buffer;
  localparam int DEPTH = 8;
  typedef struct {
    logic [31:0] pc, inst;
    bit          halt, reg_we, dmem_we;
    logic [4:0]  wa;
    logic [31:0] wd, dwa, dwd;
  } rec_t;
  typedef struct {
    bit          rdy;
    bit          valid;
    logic [31:0] data;
    bit          last;
  } vec_t;
  logic clk = 0, rst = 0, commit = 0, tr_ready = 0;
  logic [31:0] commit_pc = 0, commit_inst = 0, commit_reg_wd = 0, commit_dmem_wa = 0, commit_dmem_wd = 0;
  logic commit_halt = 0, commit_reg_we = 0, commit_dmem_we = 0;
  logic [4:0] commit_reg_wa = 0;
  logic tr_valid, tr_last, stall_req, overflow, halted;
  logic [31:0] tr_data;
  int checks = 0, failures = 0;
  rec_t q[$];
  rec_t cur;
  vec_t tbl[$];
  int widx = 0, lasts = 0;
  bit m_ovf = 0, m_halt = 0;

  commit_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .commit(commit), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_halt(commit_halt), .commit_reg_we(commit_reg_we), .commit_reg_wa(commit_reg_wa),
    .commit_reg_wd(commit_reg_wd), .commit_dmem_we(commit_dmem_we), .commit_dmem_wa(commit_dmem_wa),
    .commit_dmem_wd(commit_dmem_wd), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data),
    .tr_last(tr_last), .stall_req(stall_req), .overflow(overflow), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(rec_t r, int i);
    case (i)
      0: return r.pc;
      1: return r.inst;
      2: return {r.halt, r.reg_we, r.dmem_we, 20'b0, r.wa, 4'b0};
      3: return r.wd;
      4: return r.dwa;
      default: return r.dwd;
    endcase
  endfunction

  function automatic rec_t rand_rec(bit halt);
    rec_t r;
    r.pc = $urandom; r.inst = $urandom; r.halt = halt;
    r.reg_we = $urandom_range(0, 1) == 1; r.dmem_we = $urandom_range(0, 1) == 1;
    r.wa = 5'($urandom_range(0, 31)); r.wd = $urandom; r.dwa = $urandom; r.dwd = $urandom;
    return r;
  endfunction

  task automatic drive(bit c, rec_t r);
    cur = r; commit = c;
    commit_pc = r.pc; commit_inst = r.inst; commit_halt = r.halt; commit_reg_we = r.reg_we;
    commit_dmem_we = r.dmem_we; commit_reg_wa = r.wa; commit_reg_wd = r.wd;
    commit_dmem_wa = r.dwa; commit_dmem_wd = r.dwd;
  endtask

  // One clock: check the presented word against the model, advance model, check registered flags.
  task automatic tick();
    bit acc;
    #1;
    acc = commit && q.size() < DEPTH;
    if (q.size() == 0) chk("valid_when_empty", 32'(tr_valid), 32'd0);
    else if (tr_valid && tr_ready) begin
      chk("tr_data", tr_data, word_of(q[0], widx));
      chk("tr_last", 32'(tr_last), 32'(widx == 5));
      widx++;
      if (widx == 6) begin
        widx = 0; lasts++;
        if (q[0].halt) m_halt = 1;
        void'(q.pop_front());
      end
    end
    if (acc) q.push_back(cur);
    else if (commit) m_ovf = 1;
    @(posedge clk); #1;
    chk("stall_req", 32'(stall_req), 32'(q.size() >= DEPTH - 1));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("halted", 32'(halted), 32'(m_halt));
  endtask

  task automatic reset_dut();
    rst = 0; #2; rst = 1;
    q.delete(); widx = 0; lasts = 0; m_ovf = 0; m_halt = 0;
    @(posedge clk); #1;
  endtask

  task automatic drain(string name, int exp_recs);
    int base = lasts;
    drive(0, cur); tr_ready = 1;
    for (int i = 0; i < 300 && q.size() > 0; i++) tick();
    chk({name, "_drained"}, 32'(q.size()), 32'd0);
    chk({name, "_records"}, 32'(lasts - base), 32'(exp_recs));
  endtask

  initial begin
    rec_t r1, r2, r3;
    bit en_prev, en_now, seen;
    int pushes, stall_at;
    r1 = '{32'h00400000, 32'h00500093, 0, 1, 0, 5'd1, 32'd5, 32'd0, 32'd0};
    r2 = '{32'h00000100, 32'h00000200, 0, 0, 1, 5'd0, 32'h300, 32'h400, 32'h500};
    tbl.push_back('{1, 0, 32'h0, 0});
    tbl.push_back('{1, 1, 32'h00400000, 0});
    tbl.push_back('{1, 1, 32'h00500093, 0});
    tbl.push_back('{1, 1, 32'h40000010, 0});
    tbl.push_back('{1, 1, 32'h00000005, 0});
    tbl.push_back('{1, 1, 32'h00000000, 0});
    tbl.push_back('{1, 1, 32'h00000000, 1});
    tbl.push_back('{1, 0, 32'h0, 0});
    tbl.push_back('{0, 0, 32'h0, 0});
    for (int w = 0; w < 6; w++) begin
      tbl.push_back('{0, 1, word_of(r2, w), w == 5});
      tbl.push_back('{1, 1, word_of(r2, w), w == 5});
    end
    tbl.push_back('{0, 0, 32'h0, 0});
    #12 rst = 1;
    @(posedge clk); #1;
    chk("rst_valid", 32'(tr_valid), 0); chk("rst_data", tr_data, 0); chk("rst_last", 32'(tr_last), 0);
    chk("rst_stall", 32'(stall_req), 0); chk("rst_ovf", 32'(overflow), 0); chk("rst_halted", 32'(halted), 0);

    // Single record then a backpressured record, both from the vector table.
    drive(1, r1); tick(); drive(0, r1);
    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 8) begin drive(1, r2); tr_ready = 0; tick(); drive(0, r2); end
      tr_ready = tbl[i].rdy; #1;
      chk($sformatf("vec%0d_valid", i), 32'(tr_valid), 32'(tbl[i].valid));
      chk($sformatf("vec%0d_data", i), tr_data, tbl[i].data);
      chk($sformatf("vec%0d_last", i), 32'(tr_last), 32'(tbl[i].last));
      tick();
    end

    // Fill with a core that honours stall through its commit register.
    reset_dut(); tr_ready = 0; en_prev = 1; pushes = 0; stall_at = -1;
    for (int i = 0; i < 14; i++) begin
      drive(en_prev, rand_rec(0));
      en_now = !stall_req;
      if (en_prev) pushes++;
      tick();
      if (stall_req && stall_at < 0) stall_at = pushes;
      en_prev = en_now;
    end
    chk("fill_stall_after", 32'(stall_at), 32'd7);
    chk("fill_ovf", 32'(overflow), 0);
    drain("fill", 8);

    // Overflow: nine pushes ignoring stall.
    reset_dut(); tr_ready = 0;
    for (int i = 0; i < 9; i++) begin drive(1, rand_rec(0)); tick(); end
    drive(0, cur);
    chk("ovf_set", 32'(overflow), 32'd1);
    drain("ovf", 8);

    // Halt after three records.
    reset_dut(); tr_ready = 1;
    r3 = rand_rec(1); r3.inst = 32'h00100073;
    drive(1, rand_rec(0)); tick(); drive(1, rand_rec(0)); tick(); drive(1, r3); tick(); drive(0, r3);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      #1;
      chk("halt_early", 32'(halted), 0);
      seen = tr_valid && tr_ready && tr_last && lasts == 2;
      tick();
    end
    chk("halt_set", 32'(halted), 32'd1);

    // Async reset in the middle of a record.
    drive(1, rand_rec(0)); tick(); drive(0, cur);
    for (int i = 0; i < 20 && widx != 3; i++) tick();
    chk("mid_idx_reached", 32'(widx), 32'd3);
    rst = 0; #1;
    chk("arst_valid", 32'(tr_valid), 0); chk("arst_data", tr_data, 0); chk("arst_last", 32'(tr_last), 0);
    chk("arst_stall", 32'(stall_req), 0); chk("arst_ovf", 32'(overflow), 0); chk("arst_halted", 32'(halted), 0);
    #2; rst = 1;
    q.delete(); widx = 0; lasts = 0; m_ovf = 0; m_halt = 0;
    @(posedge clk); #1;
    r1 = rand_rec(0); drive(1, r1); tick(); drive(0, r1);
    for (int i = 0; i < 5 && !tr_valid; i++) tick();
    chk("post_rst_word0", tr_data, r1.pc);
    drain("post_rst", 1);

    // Randomized traffic, mostly stall-honouring with occasional overruns.
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 1) == 1) && (!stall_req || $urandom_range(0, 7) == 0),
            rand_rec($urandom_range(0, 15) == 0));
      tr_ready = $urandom_range(0, 9) < 7;
      tick();
    end
    drain("rand", q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
